truth_table_sweeper: RTL

Parametrised, self-checking exhaustive stimulus engine for small combinational circuits under test. On a start pulse it walks every input vector of an N-input DUT in ascending binary order. It holds each vector for a programmable settle time, then compares the DUT output against a golden-model output. It reports a pass flag, a mismatch count and the first failing vector. It sits between a bench controller and the DUT/reference pair, and replaces hand-written per-vector test sequences with a single clocked sweep.

---
 rtl/truth_table_sweeper.sv | 137 +++++++++++++
 1 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: exhaustive stimulus engine for a small combinational
// circuit. Walks every input vector in ascending order, holds each one for a
// programmable settle time, compares DUT against reference output and reports
// pass, mismatch count and the first failing vector.
module truth_table_sweeper #(
    parameter int N_IN   = 2,
    parameter int M_OUT  = 1,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [N_IN-1:0]   x,
    input  logic [M_OUT-1:0]  z_dut,
    input  logic [M_OUT-1:0]  z_ref,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic [N_IN-1:0]   first_err,
    output logic              first_err_valid
);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        CHECK,
        FIN
    } state_t;

    localparam int                CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]     SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0]   LAST_VEC    = '1;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   settle_cnt;
    logic            mismatch;

    // x doubles as the vector counter: it is zero whenever the sweeper is idle
    // and equals the current vector in HOLD/CHECK. 4-state inequality makes an
    // X/Z on either side count as a mismatch in simulation.
    assign mismatch = (z_dut !== z_ref);

    // Next-state logic for the sweep sequencer.
    always_comb begin
        // NOTE: default assigned first so every path drives state_nx and no latch is inferred.
        state_nx = state;
        unique case (state)
            IDLE:  if (start && !abort) state_nx = HOLD;
            HOLD: begin
                if (abort)                          state_nx = IDLE;
                else if (settle_cnt == SETTLE_LAST) state_nx = CHECK;
            end
            CHECK: begin
                if (abort)              state_nx = IDLE;
                else if (x == LAST_VEC) state_nx = FIN;
                else                    state_nx = HOLD;
            end
            FIN:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register plus registered outputs and sweep bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            settle_cnt      <= '0;
            x               <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err       <= '0;
            first_err_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_nx;
            busy  <= (state_nx != IDLE);
            done  <= (state_nx == FIN);
            unique case (state)
                IDLE: begin
                    // Results of the previous sweep are held until a start is accepted.
                    if (start && !abort) begin
                        x               <= '0;
                        settle_cnt      <= '0;
                        pass            <= 1'b0;
                        err_count       <= '0;
                        first_err       <= '0;
                        first_err_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (abort) begin
                        x    <= '0;
                        pass <= 1'b0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + CW'(1);
                    end
                end
                CHECK: begin
                    if (abort) begin
                        // Partial err_count/first_err are kept for inspection.
                        x    <= '0;
                        pass <= 1'b0;
                    end else begin
                        if (mismatch) begin
                            err_count <= err_count + (N_IN+1)'(1);
                            if (!first_err_valid) begin
                                first_err       <= x;
                                first_err_valid <= 1'b1;
                            end
                        end
                        if (x == LAST_VEC) begin
                            // Final verdict is registered on entry to FIN so it is
                            // valid in the same cycle as done.
                            x    <= '0;
                            pass <= (err_count == '0) && !mismatch;
                        end else begin
                            x <= x + N_IN'(1);
                        end
                    end
                end
                FIN: begin
                    // Abort is ignored here; the sweep has already completed.
                end
                default: begin
                end
            endcase
        end
    end

endmodule
